// File: rtl/deserializer_core.sv
// rtl/deserializer_core.sv - serial-to-parallel word assembler, MSB first
//
// Purpose: collects DATA_W qualified serial bits into a parallel word. The
// first accepted bit of a word becomes the MSB. The completed word is
// presented with a one-cycle strobe in the cycle after its last bit is
// accepted.
//
// Ports:
//   clk_i            - single clock, rising edge
//   srst_i           - synchronous active-high reset
//   data_i           - serial data bit, sampled only when data_val_i=1
//   data_val_i       - qualifies data_i in the current cycle
//   deser_data_o     - last complete word, held until the next one completes
//   deser_data_val_o - one-cycle strobe marking a new word on deser_data_o
module deserializer_core #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic              deser_data_val_o
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] word_q,  word_d;
    logic              val_q,   val_d;
    logic [DATA_W-1:0] shift_next;

    always_comb begin
        // Shifting left makes the earliest bit of the word end up in the MSB.
        shift_next = {shift_q[DATA_W-2:0], data_i};

        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        val_d   = 1'b0;

        if (data_val_i) begin
            shift_d = shift_next;
            if (cnt_q == LAST_BIT) begin
                // The word is taken from shift_next so the final bit is
                // included without waiting an extra cycle. The shift register
                // is not cleared: every stale bit is shifted out before the
                // next word completes.
                cnt_d  = '0;
                word_d = shift_next;
                val_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            val_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            val_q   <= val_d;
        end
    end

    assign deser_data_o     = word_q;
    assign deser_data_val_o = val_q;

endmodule

// File: tb/tb_deserializer_core.sv
// tb/tb_deserializer_core.sv - self-checking bench for deserializer_core
module tb_deserializer_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         srst_i = 1'b1;
    logic         data_i = 1'b0;
    logic         data_val_i = 1'b0;
    logic [W-1:0] deser_data_o;
    logic         deser_data_val_o;

    always #5 clk = ~clk;

    deserializer_core #(.DATA_W(W)) dut (
        .clk_i            (clk),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_val_o (deser_data_val_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bits accepted so far for the word under collection.
    bit           m_bits[$];
    bit           m_val  = 1'b0;
    logic [W-1:0] m_word = '0;

    // Observed strobes.
    int           cyc     = 0;
    int           strobes = 0;
    int           strobe_cyc[$];
    logic [W-1:0] strobe_words[$];

    typedef struct {
        bit           r;
        bit           v;
        bit           d;
        bit           e_val;
        logic [W-1:0] e_word;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model for the edge, sample 1ns later.
    task automatic step(input bit r, input bit v, input bit d, input bit chk);
        logic [W-1:0] w;
        srst_i     = r;
        data_val_i = v;
        data_i     = d;
        @(posedge clk);
        if (r) begin
            m_bits.delete();
            m_val  = 1'b0;
            m_word = '0;
        end else begin
            m_val = 1'b0;
            if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() == W) begin
                    w = '0;
                    foreach (m_bits[i]) w[W-1-i] = m_bits[i];
                    m_word = w;
                    m_val  = 1'b1;
                    m_bits.delete();
                end
            end
        end
        #1;
        cyc++;
        if (deser_data_val_o === 1'b1) begin
            strobes++;
            strobe_cyc.push_back(cyc);
            strobe_words.push_back(deser_data_o);
        end
        if (chk) begin
            check("strobe", {63'd0, deser_data_val_o}, {63'd0, m_val});
            check("word", {48'd0, deser_data_o}, {48'd0, m_word});
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap_pct, input bit chk);
        for (int i = W - 1; i >= 0; i--) begin
            for (int g = 0; g < 8; g++) begin
                if ($urandom_range(99, 0) >= gap_pct) break;
                step(1'b0, 1'b0, 1'($urandom_range(1, 0)), chk);
            end
            step(1'b0, 1'b1, w[i], chk);
        end
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] sent[$];
        int           s0;
        int           last_bit_cyc;

        // Table-driven: reset, then 0xA5C3 back-to-back, then one idle cycle.
        pat = 16'hA5C3;
        tbl.push_back('{r: 1'b1, v: 1'b1, d: 1'b1, e_val: 1'b0, e_word: '0});
        for (int i = 0; i < W; i++)
            tbl.push_back('{r: 1'b0, v: 1'b1, d: pat[W-1-i],
                            e_val: (i == W - 1), e_word: (i == W - 1) ? pat : '0});
        tbl.push_back('{r: 1'b0, v: 1'b0, d: 1'b1, e_val: 1'b0, e_word: pat});

        step(1'b1, 1'b0, 1'b0, 1'b0);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, 1'b0);
            check($sformatf("tbl_val[%0d]", i), {63'd0, deser_data_val_o}, {63'd0, tbl[i].e_val});
            check($sformatf("tbl_word[%0d]", i), {48'd0, deser_data_o}, {48'd0, tbl[i].e_word});
        end

        // 0x8001 with ~50% gaps; data toggles randomly during gaps.
        s0 = strobes;
        send_word(16'h8001, 50, 1'b1);
        last_bit_cyc = cyc;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'($urandom_range(1, 0)), 1'b1);
        check("gap_strobe_count", 64'(strobes - s0), 64'd1);
        if (strobes - s0 == 1) begin
            check("gap_word", {48'd0, strobe_words[$]}, 64'h8001);
            check("gap_latency", 64'(strobe_cyc[$]), 64'(last_bit_cyc));
        end

        // Back-to-back 0xFFFF then 0x0000 with data_val_i held high.
        s0 = strobes;
        send_word(16'hFFFF, 0, 1'b1);
        send_word(16'h0000, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b_strobe_count", 64'(strobes - s0), 64'd2);
        if (strobes - s0 == 2) begin
            check("b2b_spacing", 64'(strobe_cyc[$] - strobe_cyc[$-1]), 64'd16);
            check("b2b_word0", {48'd0, strobe_words[$-1]}, 64'hFFFF);
            check("b2b_word1", {48'd0, strobe_words[$]}, 64'h0000);
        end

        // Partial word, reset carrying a valid bit, then 0x1234.
        s0 = strobes;
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'($urandom_range(1, 0)), 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_no_strobe", 64'(strobes - s0), 64'd0);
        check("rst_word_cleared", {48'd0, deser_data_o}, 64'd0);
        send_word(16'h1234, 30, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_strobe_count", 64'(strobes - s0), 64'd1);
        if (strobes - s0 == 1)
            check("rst_word", {48'd0, strobe_words[$]}, 64'h1234);

        // 100 random words with random gaps, model-checked every cycle.
        s0 = strobes;
        for (int k = 0; k < 100; k++) begin
            pat = W'($urandom);
            sent.push_back(pat);
            send_word(pat, $urandom_range(60, 0), 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rand_strobe_count", 64'(strobes - s0), 64'd100);
        if (strobes - s0 == 100) begin
            for (int k = 0; k < 100; k++)
                if (strobe_words[s0 + k] !== sent[k])
                    check($sformatf("rand_word[%0d]", k), {48'd0, strobe_words[s0 + k]}, {48'd0, sent[k]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/deserializer_core.md
DESERIALIZER_CORE -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the output word width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port srst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port data_i, input, 1 bit: serial data bit, meaningful only when data_val_i=1.
REQ-005 The block SHALL have port data_val_i, input, 1 bit: qualifies data_i for the current cycle.
REQ-006 The block SHALL have port deser_data_o, output, DATA_W bits: the assembled parallel word.
REQ-007 The block SHALL have port deser_data_val_o, output, 1 bit: one-cycle strobe marking deser_data_o as a new word.

Function
REQ-008 The block SHALL sample data_i on a rising clk_i edge only when data_val_i=1; data_i SHALL be ignored when data_val_i=0.
REQ-009 Input gaps SHALL be allowed: cycles with data_val_i=0 between valid bits SHALL not alter the partial word or the bit count.
REQ-010 Ordering SHALL be MSB first: the 1st valid bit of a word lands in deser_data_o[DATA_W-1]; the DATA_W-th lands in bit 0.
REQ-011 An internal bit counter SHALL count valid bits 0..DATA_W-1 and wrap to 0 when the DATA_W-th valid bit is accepted.
REQ-012 On the edge accepting the DATA_W-th valid bit, the block SHALL register the complete word into deser_data_o and set deser_data_val_o=1.
REQ-013 Latency: deser_data_val_o SHALL be high in the clock cycle immediately after that edge, with the word visible on deser_data_o in the same cycle.
REQ-014 deser_data_val_o SHALL be high for exactly one cycle per word and low in all other cycles, including all cycles while a word is being collected.
REQ-015 deser_data_o SHALL hold the last complete word until the next word completes; partial words SHALL never appear on deser_data_o.
REQ-016 Back-to-back words SHALL be supported: a valid bit arriving in the strobe cycle SHALL be the MSB of the next word, with no lost cycles.
REQ-017 Continuous input (data_val_i=1 every cycle) SHALL produce one strobe every DATA_W cycles.

Reset
REQ-018 While srst_i=1 at a rising edge, the block SHALL clear the bit counter and the partial word, and set deser_data_o to 0 and deser_data_val_o to 0.
REQ-019 Reset SHALL take priority over data_val_i; a valid bit in a reset cycle SHALL be discarded.
REQ-020 Reset mid-word SHALL discard the partial word; the first valid bit after reset SHALL be treated as an MSB.

Structure
REQ-021 The block SHALL need no shared package; counter width SHALL be derived locally as $clog2(DATA_W).
REQ-022 The block SHALL be a single module with no sub-modules: one shift register, one bit counter, one output word register and one strobe register.

Verification (DATA_W=16)
REQ-023 Scenario: 16 consecutive valid bits of 0xA5C3 -> deser_data_val_o=1 for one cycle in the cycle after the 16th bit, deser_data_o=0xA5C3; strobe 0 throughout.
REQ-024 Scenario: 0x8001 sent with random data_val_i gaps at 50% density -> a single strobe one cycle after the last valid bit, word 0x8001; data_i toggled during gaps has no effect.
REQ-025 Scenario: two back-to-back words 0xFFFF then 0x0000 with data_val_i held high -> strobes 16 cycles apart, words 0xFFFF then 0x0000.
REQ-026 Scenario: 7 valid bits, srst_i pulse, then 16 bits of 0x1234 -> no strobe before the reset, exactly one strobe afterwards, word 0x1234.
REQ-027 Scenario: 100 random words with random gaps -> every word matches and exactly 100 strobes occur; deser_data_o stays stable between strobes.
